// File: rtl/bin2bcd_seq_pkg.sv
// bin2bcd_seq_pkg: shared FSM state type and BCD digit constants for bin2bcd_seq
package bin2bcd_seq_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam int BCD_DIGIT_W    = 4;
    localparam int BCD_ADJ_THRESH = 5;
    localparam int BCD_ADJ_ADD    = 3;
endpackage

// File: rtl/bin2bcd_seq_digit_adj.sv
// bcd_digit_adj: add-3 correction of one BCD digit before a shift (din in, dout out)
module bcd_digit_adj
    import bin2bcd_seq_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout
);
    assign dout = (din >= BCD_DIGIT_W'(BCD_ADJ_THRESH)) ? din + BCD_DIGIT_W'(BCD_ADJ_ADD) : din;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-and-add-3 binary to BCD converter; ports clk, rst (async), start/bin_in in, busy/done/bcd_out/ovf/neg out; BIN2BCD_SIGNED_EN enables two's complement input
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [WIDTH-1:0]            bin_in,
    output logic                        busy,
    output logic                        done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                        ovf,
    output logic                        neg
);
    localparam int BW = BCD_DIGIT_W * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, state_nx;
    logic [BW-1:0]    scratch, adj, scratch_nx;
    logic [WIDTH-1:0] shreg, load_val;
    logic [CW-1:0]    cnt;
    logic             sticky, sticky_nx, last, accept;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .dout (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    assign accept     = (state == IDLE) && start;
    assign last       = (cnt == CW'(1));
    // Adjusted scratch shifted left with the operand MSB entering at bit 0; the bit leaving the top digit marks overflow
    assign scratch_nx = {adj[BW-2:0], shreg[WIDTH-1]};
    assign sticky_nx  = sticky | adj[BW-1];

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;

    always_comb begin
        state_nx = state;
        busy     = (state != IDLE);
        done     = (state == DONE);
        if (accept)                        state_nx = SHIFT;
        else if ((state == SHIFT) && last) state_nx = DONE;
        else if (state == DONE)            state_nx = IDLE;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            scratch <= '0;
            shreg   <= '0;
            cnt     <= '0;
            sticky  <= 1'b0;
            bcd_out <= '0;
            ovf     <= 1'b0;
        end else if (accept) begin
            scratch <= '0;
            shreg   <= load_val;
            cnt     <= CW'(WIDTH);
            sticky  <= 1'b0;
        end else if (state == SHIFT) begin
            scratch <= scratch_nx;
            shreg   <= shreg << 1;
            cnt     <= cnt - CW'(1);
            sticky  <= sticky_nx;
            if (last) begin
                bcd_out <= scratch_nx;
                ovf     <= sticky_nx;
            end
        end

`ifdef BIN2BCD_SIGNED_EN
    logic sign;
    // Magnitude fits WIDTH bits unsigned, so the most negative value converts correctly
    assign load_val = bin_in[WIDTH-1] ? WIDTH'(-bin_in) : bin_in;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sign <= 1'b0;
            neg  <= 1'b0;
        end else if (accept) begin
            sign <= bin_in[WIDTH-1];
        end else if ((state == SHIFT) && last) begin
            neg <= sign;
        end
`else
    assign load_val = bin_in;
    assign neg      = 1'b0;
`endif
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench for bin2bcd_seq (5-digit and 4-digit instances)
module tb_bin2bcd_seq;
    typedef struct {
        logic [19:0] bcd;
        logic        ovf;
        logic        neg;
    } exp_t;

    logic        clk, rst;
    logic        start, start4;
    logic [15:0] bin_in, bin4;
    logic        busy, done, ovf, neg;
    logic        busy4, done4, ovf4, neg4;
    logic [19:0] bcd_out;
    logic [15:0] bcd4;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
        .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
        .busy(busy), .done(done), .bcd_out(bcd_out), .ovf(ovf), .neg(neg)
    );

    bin2bcd_seq #(.WIDTH(16), .DIGITS(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .bin_in(bin4),
        .busy(busy4), .done(done4), .bcd_out(bcd4), .ovf(ovf4), .neg(neg4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t model(input logic [15:0] v, input int digits);
        exp_t e;
        int   mag;
        e.bcd = '0;
`ifdef BIN2BCD_SIGNED_EN
        e.neg = v[15];
        mag   = v[15] ? 65536 - int'(v) : int'(v);
`else
        e.neg = 1'b0;
        mag   = int'(v);
`endif
        for (int i = 0; i < digits; i++) begin
            e.bcd[4*i +: 4] = 4'(mag % 10);
            mag = mag / 10;
        end
        e.ovf = (mag != 0);
        return e;
    endfunction

    task automatic convert(input bit four, input logic [15:0] v,
                           output int lat, output int busy_n, output int done_n);
        sb.push_back(model(v, four ? 4 : 5));
        lat = -1; busy_n = 0; done_n = 0;
        if (four) begin bin4 = v; start4 = 1'b1; end
        else      begin bin_in = v; start = 1'b1; end
        for (int s = 0; s < 20; s++) begin
            @(posedge clk); #1;
            start = 1'b0; start4 = 1'b0;
            busy_n += int'(four ? busy4 : busy);
            if (four ? done4 : done) begin
                done_n++;
                if (lat < 0) lat = s;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)     begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (bcd_out !== 20'h0) begin n_bad++; $display("FAIL reset_bcd got %h want 00000", bcd_out); end
        n_cmp++; if (ovf !== 1'b0)      begin n_bad++; $display("FAIL reset_ovf got %b want 0", ovf); end
        n_cmp++; if (neg !== 1'b0)      begin n_bad++; $display("FAIL reset_neg got %b want 0", neg); end
        n_cmp++; if (busy4 !== 1'b0)    begin n_bad++; $display("FAIL reset_busy4 got %b want 0", busy4); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_values();
        logic [15:0] vals[5] = '{16'd0, 16'd65535, 16'h8000, 16'h7FFF, 16'd9};
        int lat, bn, dn;
        exp_t e;
        foreach (vals[i]) begin
            convert(1'b0, vals[i], lat, bn, dn);
            e = sb.pop_front();
            n_cmp++; if (lat !== 16)       begin n_bad++; $display("FAIL latency_%0d got %0d want 16", i, lat); end
            n_cmp++; if (bcd_out !== e.bcd) begin n_bad++; $display("FAIL bcd_%0d got %h want %h", i, bcd_out, e.bcd); end
            n_cmp++; if (ovf !== e.ovf)     begin n_bad++; $display("FAIL ovf_%0d got %b want %b", i, ovf, e.ovf); end
            n_cmp++; if (neg !== e.neg)     begin n_bad++; $display("FAIL neg_%0d got %b want %b", i, neg, e.neg); end
            if (i == 1) begin
                n_cmp++; if (bn !== 17) begin n_bad++; $display("FAIL busy_cycles got %0d want 17", bn); end
                n_cmp++; if (dn !== 1)  begin n_bad++; $display("FAIL done_cycles got %0d want 1", dn); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int d_at[$];
        exp_t e;
        repeat (3) sb.push_back(model(16'd1234, 5));
        bin_in = 16'd1234;
        start  = 1'b1;
        for (int s = 0; s < 54; s++) begin
            @(posedge clk); #1;
            if (done) begin
                d_at.push_back(s);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    n_cmp++; if (bcd_out !== e.bcd) begin n_bad++; $display("FAIL b2b_bcd got %h want %h", bcd_out, e.bcd); end
                end
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle got %b want 0", busy); end
        n_cmp++; if (d_at.size() !== 3) begin n_bad++; $display("FAIL b2b_count got %0d want 3", d_at.size()); end
        if (d_at.size() == 3) begin
            n_cmp++; if (d_at[0] !== 16) begin n_bad++; $display("FAIL b2b_first got %0d want 16", d_at[0]); end
            n_cmp++; if (d_at[1] - d_at[0] !== 18) begin n_bad++; $display("FAIL b2b_gap1 got %0d want 18", d_at[1] - d_at[0]); end
            n_cmp++; if (d_at[2] - d_at[1] !== 18) begin n_bad++; $display("FAIL b2b_gap2 got %0d want 18", d_at[2] - d_at[1]); end
        end
        sb.delete();
    endtask

    task automatic test_start_ignored();
        int dn = 0;
        exp_t e;
        sb.push_back(model(16'd4321, 5));
        bin_in = 16'd4321;
        start  = 1'b1;
        for (int s = 0; s < 20; s++) begin
            @(posedge clk); #1;
            start = (s == 5) || (s == 16);
            if (s == 5) bin_in = 16'd9999;
            if (done) dn++;
        end
        start = 1'b0;
        e = sb.pop_front();
        n_cmp++; if (bcd_out !== e.bcd) begin n_bad++; $display("FAIL ignore_bcd got %h want %h", bcd_out, e.bcd); end
        n_cmp++; if (dn !== 1)          begin n_bad++; $display("FAIL ignore_dones got %0d want 1", dn); end
        n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL ignore_busy got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int lat, bn, dn;
        exp_t e;
        bin_in = 16'd9999;
        start  = 1'b1;
        for (int s = 0; s <= 8; s++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL midrst_busy got %b want 0", busy); end
        n_cmp++; if (bcd_out !== 20'h0) begin n_bad++; $display("FAIL midrst_bcd got %h want 00000", bcd_out); end
        n_cmp++; if (ovf !== 1'b0 || neg !== 1'b0 || done !== 1'b0)
            begin n_bad++; $display("FAIL midrst_flags got %b%b%b want 000", ovf, neg, done); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        convert(1'b0, 16'd42, lat, bn, dn);
        e = sb.pop_front();
        n_cmp++; if (bcd_out !== e.bcd) begin n_bad++; $display("FAIL post_rst_bcd got %h want %h", bcd_out, e.bcd); end
        n_cmp++; if (lat !== 16)        begin n_bad++; $display("FAIL post_rst_lat got %0d want 16", lat); end
    endtask

    task automatic test_overflow();
        logic [15:0] vals[4] = '{16'd65535, 16'd7, 16'd10000, 16'd9999};
        int lat, bn, dn;
        exp_t e;
        foreach (vals[i]) begin
            convert(1'b1, vals[i], lat, bn, dn);
            e = sb.pop_front();
            n_cmp++; if (bcd4 !== e.bcd[15:0]) begin n_bad++; $display("FAIL ovf4_bcd_%0d got %h want %h", i, bcd4, e.bcd[15:0]); end
            n_cmp++; if (ovf4 !== e.ovf)       begin n_bad++; $display("FAIL ovf4_flag_%0d got %b want %b", i, ovf4, e.ovf); end
            n_cmp++; if (neg4 !== e.neg)       begin n_bad++; $display("FAIL ovf4_neg_%0d got %b want %b", i, neg4, e.neg); end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start4 = 1'b0; bin_in = '0; bin4 = '0;
        test_reset();
        test_values();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid();
        test_overflow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter using the shift-and-add-3 method. It sits between the CPU's 16-bit display/output register and the bank of per-digit seven-segment decoders. Each 4-bit BCD nibble of its output drives one digit decoder directly, so register values appear on the board in decimal. Conversions run one bit per clock under a start/busy/done handshake.

## Interface
- `WIDTH`, default 16: width of the binary input.
- `DIGITS`, default 5: number of BCD digits produced. `DIGITS` ≥ ceil(`WIDTH`·log10 2) gives a lossless result.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a conversion; honoured only while `busy`=0.
- `bin_in`  in  `WIDTH`  binary operand; sampled in the cycle `start` is accepted.
- `busy`  out  1  high while a conversion is in progress.
- `done`  out  1  one-cycle pulse when `bcd_out` has just been updated.
- `bcd_out`  out  4·`DIGITS`  result; digit 0 (ones) is in bits [3:0]. Held between conversions.
- `ovf`  out  1  result did not fit in `DIGITS`; registered with `bcd_out`.
- `neg`  out  1  operand was negative (signed build only); registered with `bcd_out`.

## Operation
- FSM states: IDLE, SHIFT, DONE. `busy` = (state ≠ IDLE).
- IDLE + `start`:
  - load the shift register with `bin_in` (or its magnitude, see Configuration);
  - clear the BCD scratch register and the overflow sticky bit;
  - set the bit counter to `WIDTH`;
  - go to SHIFT.
- SHIFT, each cycle:
  - every scratch digit ≥ 5 gets +3;
  - {scratch, shift} shifts left by 1; the shift MSB enters scratch bit 0;
  - a 1 shifted out of the top scratch bit sets the overflow sticky;
  - the counter decrements; after the `WIDTH`-th shift, go to DONE.
- Entering DONE: `bcd_out` ← scratch, `ovf` ← sticky, `neg` ← captured sign.
- DONE: `done`=1 for exactly this one cycle, then return to IDLE.
- `start` in SHIFT or DONE is ignored. There is no queuing, and `bin_in` is not re-sampled.
- When overflowing, `bcd_out` = value mod 10^`DIGITS`.
- Reset (any time, including mid-conversion):
  - state goes to IDLE;
  - `busy`, `done`, `ovf`, `neg` = 0;
  - `bcd_out` = 0, which displays all zeros;
  - scratch, shift register and counter are cleared.
  - An interrupted conversion is discarded.

## Timing
- `start` accepted at edge 0:
  - `busy`=1 after edge 0;
  - shifts occur on edges 1..`WIDTH`;
  - `done`=1 and the new `bcd_out` are visible after edge `WIDTH`;
  - `busy`=0 after edge `WIDTH`+1.
- Latency from accept to `done` is `WIDTH` cycles (16 by default).
- Earliest next accepted `start` is edge `WIDTH`+2, so throughput is one conversion per `WIDTH`+2 cycles.
- `bcd_out`, `ovf` and `neg` change only on the edge that raises `done`, or on reset. They are glitch-free for the downstream decoders.

## Configuration
- Macro: `BIN2BCD_SIGNED_EN`.
- Defined:
  - `bin_in` is two's complement;
  - at accept, the sign is captured and the shift register loads |`bin_in`| as a `WIDTH`-bit unsigned value (0x8000 → 32768);
  - `neg` reports the sign.
- Undefined:
  - `bin_in` is unsigned;
  - the `neg` port still exists and is tied to 0.

## Structure
- Shared package holds:
  - the state enum (IDLE/SHIFT/DONE);
  - `BCD_DIGIT_W` = 4;
  - `BCD_ADJ_THRESH` = 5;
  - `BCD_ADJ_ADD` = 3.
- Sub-module `bcd_digit_adj`: combinational per-digit add-3 correction, 4-bit in and 4-bit out, generated `DIGITS` times.
- The counter is clog2(`WIDTH`+1) bits wide.

## Test plan
- `bin_in`=0, `start` pulse → `done` at edge 16; `bcd_out`=0x00000, `ovf`=0.
- `bin_in`=65535 → `bcd_out`=0x65535, `ovf`=0. Check `busy` high for exactly 17 cycles and `done` high for exactly 1.
- `bin_in`=1234, then `start` held high continuously → `bcd_out`=0x01234. Back-to-back accepts occur every 18 cycles; `start` pulses while busy have no effect.
- Assert `rst` at shift 8 of a 9999 conversion → all outputs 0 immediately. A new conversion of 42 afterwards → `bcd_out`=0x00042.
- `DIGITS`=4, `bin_in`=65535 → `bcd_out`=0x5535, `ovf`=1. A following conversion of 7 clears `ovf`.
- With `BIN2BCD_SIGNED_EN`:
  - 0xFFFF → `neg`=1, 0x00001;
  - 0x8000 → `neg`=1, 0x32768;
  - 0x7FFF → `neg`=0, 0x32767.
